// File: rtl/feeder_pkg.sv
// Shared types and constants for the systolic-array operand feeders.
// The word layout is four int8 lanes, with lane 3 in the top byte.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } feeder_state_e;

    localparam int ARRAY_DIM     = 4;
    localparam int FLUSH_DEFAULT = ARRAY_DIM - 1;
    localparam int LANE_W        = 8;
    localparam int LANE_N        = 4;
    localparam int WORD_W        = LANE_W * LANE_N;

    // Cycles spent after the last read: SRAM drain, output register, zero flush.
    function automatic int tail_cycles(input int sram_lat, input int flush);
        return sram_lat + 1 + flush;
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Delays the SRAM read enable by the SRAM read latency.
// Its output marks the cycle in which sram_rdata holds a requested word.
module rd_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic en_dly
);

    logic [DEPTH-1:0] pipe_r;

    // Shift register carrying the read enable through the SRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_r <= {DEPTH{1'b0}};
        end else begin
            pipe_r[0] <= en;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign en_dly = pipe_r[DEPTH-1];

endmodule

// File: rtl/a_tile_feeder.sv
// Streams K activation words from the global-buffer SRAM into the skew buffer,
// then FLUSH zero words so the diagonal skew drains, then pulses done.
module a_tile_feeder
    import feeder_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int K_W      = 16,
    parameter int SRAM_LAT = 1,
    parameter int FLUSH    = FLUSH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [K_W-1:0]    k_len,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [WORD_W-1:0] sram_rdata,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    localparam int TAIL_LEN = tail_cycles(SRAM_LAT, FLUSH);
    localparam int TAIL_W   = $clog2(TAIL_LEN + 1);

    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);
    localparam logic [TAIL_W-1:0] TAIL_ZERO = {TAIL_W{1'b0}};
    localparam logic [TAIL_W-1:0] TAIL_ONE  = TAIL_W'(1);
    localparam logic [K_W-1:0]    K_ZERO    = {K_W{1'b0}};
    localparam logic [K_W-1:0]    K_ONE     = K_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    feeder_state_e     state_r,     state_nxt_s;
    logic [K_W-1:0]    k_r,         k_nxt_s;
    logic [K_W-1:0]    rd_cnt_r,    rd_cnt_nxt_s;
    logic [TAIL_W-1:0] tail_cnt_r,  tail_cnt_nxt_s;
    logic              sram_en_r,   sram_en_nxt_s;
    logic [ADDR_W-1:0] sram_addr_r, sram_addr_nxt_s;
    logic              busy_r,      busy_nxt_s;
    logic              done_r,      done_nxt_s;
    logic [WORD_W-1:0] data_out_r;
    logic              data_valid_r;
    logic              rd_tail_s;

    // Next state and next registered outputs; rd_cnt counts addresses already issued.
    always_comb begin
        state_nxt_s     = state_r;
        k_nxt_s         = k_r;
        rd_cnt_nxt_s    = rd_cnt_r;
        tail_cnt_nxt_s  = tail_cnt_r;
        sram_en_nxt_s   = 1'b0;
        sram_addr_nxt_s = sram_addr_r;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    k_nxt_s    = k_len;
                    busy_nxt_s = 1'b1;
                    if (k_len != K_ZERO) begin
                        state_nxt_s     = READ;
                        sram_en_nxt_s   = 1'b1;
                        sram_addr_nxt_s = base_addr;
                        rd_cnt_nxt_s    = K_ONE;
                    end else begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                busy_nxt_s = 1'b1;
                if (rd_cnt_r == k_r) begin
                    state_nxt_s    = TAIL;
                    tail_cnt_nxt_s = TAIL_ZERO;
                end else begin
                    sram_en_nxt_s   = 1'b1;
                    sram_addr_nxt_s = sram_addr_r + ADDR_ONE;
                    rd_cnt_nxt_s    = rd_cnt_r + K_ONE;
                end
            end
            TAIL: begin
                busy_nxt_s = 1'b1;
                if (tail_cnt_r == TAIL_LAST) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    tail_cnt_nxt_s = tail_cnt_r + TAIL_ONE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state and control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            k_r         <= K_ZERO;
            rd_cnt_r    <= K_ZERO;
            tail_cnt_r  <= TAIL_ZERO;
            sram_en_r   <= 1'b0;
            sram_addr_r <= {ADDR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            rd_cnt_r    <= rd_cnt_nxt_s;
            tail_cnt_r  <= tail_cnt_nxt_s;
            sram_en_r   <= sram_en_nxt_s;
            sram_addr_r <= sram_addr_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    rd_valid_pipe #(
        .DEPTH (SRAM_LAT)
    ) u_rd_valid_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (sram_en_r),
        .en_dly (rd_tail_s)
    );

    // Output word register: SRAM data when a requested word is present, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r   <= {WORD_W{1'b0}};
            data_valid_r <= 1'b0;
        end else if (rd_tail_s) begin
            data_out_r   <= sram_rdata;
            data_valid_r <= 1'b1;
        end else begin
            data_out_r   <= {WORD_W{1'b0}};
            data_valid_r <= 1'b0;
        end
    end

    assign sram_en    = sram_en_r;
    assign sram_addr  = sram_addr_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
